// File: rtl/hu_load_use_idex_if.sv
// Bundle between decode, writeback, the hazard controller and the execute stage.
// The master side drives decode/writeback/control inputs and observes the
// registered E stage plus stall/flush outputs; the slave side is the ID/EX block.
interface hu_load_use_idex_if #(
    parameter int CTRL_W = 4
);
    // Decode-stage instruction
    logic              valid_D;
    logic [31:0]       PC_reg_D;
    logic [31:0]       rdata1_D;
    logic [31:0]       rdata2_D;
    logic [31:0]       imme_D;
    logic [4:0]        Rs1_D;
    logic [4:0]        Rs2_D;
    logic [4:0]        Rd_D;
    logic              reg_ren_D;
    logic              RegWrite_D;
    logic              MemRead_D;
    logic              MemWrite_D;
    logic              auipc_D;
    logic              ALU_DB_Src_D;
    logic [CTRL_W-1:0] ALU_ctrl_D;

    // Writeback port, used for same-cycle bypass into captured operands
    logic              RegWrite_W;
    logic [4:0]        Rd_W;
    logic [31:0]       rdata_reg_W;

    // Pipeline control inputs
    logic              flush_E;
    logic              stall_ext;

    // Registered execute stage
    logic              valid_E;
    logic [31:0]       PC_reg_E;
    logic [31:0]       rdata1_E;
    logic [31:0]       rdata2_E;
    logic [31:0]       imme_E;
    logic [4:0]        Rs1_E;
    logic [4:0]        Rs2_E;
    logic [4:0]        Rd_E;
    logic              reg_ren_E;
    logic              RegWrite_E;
    logic              MemRead_E;
    logic              MemWrite_E;
    logic              auipc_E;
    logic              ALU_DB_Src_E;
    logic [CTRL_W-1:0] ALU_ctrl_E;

    // Front-end control outputs and statistics
    logic              stall_F;
    logic              stall_D;
    logic              flush_D;
    logic [31:0]       bubble_cnt;

    modport master (
        output valid_D, PC_reg_D, rdata1_D, rdata2_D, imme_D, Rs1_D, Rs2_D, Rd_D,
               reg_ren_D, RegWrite_D, MemRead_D, MemWrite_D, auipc_D, ALU_DB_Src_D,
               ALU_ctrl_D, RegWrite_W, Rd_W, rdata_reg_W, flush_E, stall_ext,
        input  valid_E, PC_reg_E, rdata1_E, rdata2_E, imme_E, Rs1_E, Rs2_E, Rd_E,
               reg_ren_E, RegWrite_E, MemRead_E, MemWrite_E, auipc_E, ALU_DB_Src_E,
               ALU_ctrl_E, stall_F, stall_D, flush_D, bubble_cnt
    );

    modport slave (
        input  valid_D, PC_reg_D, rdata1_D, rdata2_D, imme_D, Rs1_D, Rs2_D, Rd_D,
               reg_ren_D, RegWrite_D, MemRead_D, MemWrite_D, auipc_D, ALU_DB_Src_D,
               ALU_ctrl_D, RegWrite_W, Rd_W, rdata_reg_W, flush_E, stall_ext,
        output valid_E, PC_reg_E, rdata1_E, rdata2_E, imme_E, Rs1_E, Rs2_E, Rd_E,
               reg_ren_E, RegWrite_E, MemRead_E, MemWrite_E, auipc_E, ALU_DB_Src_E,
               ALU_ctrl_E, stall_F, stall_D, flush_D, bubble_cnt
    );
endinterface

// File: rtl/hu_load_use_idex.sv
// ID/EX pipeline register with integrated load-use hazard control.
// A load in E whose destination is read by the D instruction forces
// LOAD_BUBBLES bubbles into E while F and D are held. Branch redirect from E
// squashes both D and E and wins over everything; an external memory stall
// freezes the whole block. Writeback data landing in the same cycle as capture
// is bypassed into the captured operands.
module hu_load_use_idex #(
    parameter int LOAD_BUBBLES = 1,
    parameter int CTRL_W       = 4
) (
    input  logic               clk,
    input  logic               rst,
    hu_load_use_idex_if.slave  bus
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        LD_CAPTURE = 2'd0,
        LD_BUBBLE  = 2'd1,
        LD_HOLD    = 2'd2
    } load_sel_t;

    // Remaining bubbles after the first one of a hazard sequence
    localparam logic [2:0] CNT_INIT = 3'(LOAD_BUBBLES - 1);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    load_sel_t         load_sel;
    logic              bubble_inc;
    logic [31:0]       bubble_cnt_q, bubble_cnt_d;
    logic              hazard;
    logic              stall_out;

    // E-stage registers
    logic              valid_q;
    logic [31:0]       pc_q;
    logic [31:0]       rdata1_q;
    logic [31:0]       rdata2_q;
    logic [31:0]       imme_q;
    logic [4:0]        rs1_q;
    logic [4:0]        rs2_q;
    logic [4:0]        rd_q;
    logic              reg_ren_q;
    logic              regwrite_q;
    logic              memread_q;
    logic              memwrite_q;
    logic              auipc_q;
    logic              alu_db_src_q;
    logic [CTRL_W-1:0] alu_ctrl_q;

    // Operands with same-cycle writeback bypass applied
    logic              byp1, byp2;
    logic [31:0]       rdata1_byp, rdata2_byp;

    assign hazard = valid_q && memread_q && (rd_q != 5'd0) &&
                    bus.valid_D && bus.reg_ren_D &&
                    ((bus.Rs1_D == rd_q) || (bus.Rs2_D == rd_q));

    assign byp1 = bus.RegWrite_W && (bus.Rd_W != 5'd0) && (bus.Rd_W == bus.Rs1_D);
    assign byp2 = bus.RegWrite_W && (bus.Rd_W != 5'd0) && (bus.Rd_W == bus.Rs2_D);
    assign rdata1_byp = byp1 ? bus.rdata_reg_W : bus.rdata1_D;
    assign rdata2_byp = byp2 ? bus.rdata_reg_W : bus.rdata2_D;

    // FSM state register: RUN/STALL and bubble down-counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic in priority order: flush, external stall, hazard/stall, run
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        load_sel   = LD_CAPTURE;
        bubble_inc = 1'b0;
        if (bus.flush_E) begin
            load_sel = LD_BUBBLE;
            state_d  = ST_RUN;
            cnt_d    = 3'd0;
        end else if (bus.stall_ext) begin
            load_sel = LD_HOLD;
        end else if (state_q == ST_STALL) begin
            // Hazards are not re-evaluated while draining the current sequence
            load_sel   = LD_BUBBLE;
            bubble_inc = 1'b1;
            cnt_d      = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
                state_d = ST_RUN;
            end
        end else if (hazard) begin
            load_sel   = LD_BUBBLE;
            bubble_inc = 1'b1;
            if (LOAD_BUBBLES > 1) begin
                state_d = ST_STALL;
                cnt_d   = CNT_INIT;
            end
        end
    end

    // Front-end control outputs, combinational so the hold is zero-latency
    always_comb begin
        stall_out = 1'b0;
        if (!bus.flush_E) begin
            stall_out = bus.stall_ext || (state_q == ST_STALL) || hazard;
        end
    end

    assign bus.stall_F = stall_out;
    assign bus.stall_D = stall_out;
    assign bus.flush_D = bus.flush_E;

    // Bubble statistics counter, wraps naturally at 2^32
    assign bubble_cnt_d = bubble_cnt_q + (bubble_inc ? 32'd1 : 32'd0);

    // Bubble counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt_q <= 32'd0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    // E-stage register: capture D (invalid D becomes a bubble), insert bubble, or hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= 1'b0;
            pc_q         <= 32'd0;
            rdata1_q     <= 32'd0;
            rdata2_q     <= 32'd0;
            imme_q       <= 32'd0;
            rs1_q        <= 5'd0;
            rs2_q        <= 5'd0;
            rd_q         <= 5'd0;
            reg_ren_q    <= 1'b0;
            regwrite_q   <= 1'b0;
            memread_q    <= 1'b0;
            memwrite_q   <= 1'b0;
            auipc_q      <= 1'b0;
            alu_db_src_q <= 1'b0;
            alu_ctrl_q   <= '0;
        end else if (load_sel == LD_BUBBLE ||
                     (load_sel == LD_CAPTURE && !bus.valid_D)) begin
            valid_q      <= 1'b0;
            pc_q         <= 32'd0;
            rdata1_q     <= 32'd0;
            rdata2_q     <= 32'd0;
            imme_q       <= 32'd0;
            rs1_q        <= 5'd0;
            rs2_q        <= 5'd0;
            rd_q         <= 5'd0;
            reg_ren_q    <= 1'b0;
            regwrite_q   <= 1'b0;
            memread_q    <= 1'b0;
            memwrite_q   <= 1'b0;
            auipc_q      <= 1'b0;
            alu_db_src_q <= 1'b0;
            alu_ctrl_q   <= '0;
        end else if (load_sel == LD_CAPTURE) begin
            valid_q      <= 1'b1;
            pc_q         <= bus.PC_reg_D;
            rdata1_q     <= rdata1_byp;
            rdata2_q     <= rdata2_byp;
            imme_q       <= bus.imme_D;
            rs1_q        <= bus.Rs1_D;
            rs2_q        <= bus.Rs2_D;
            rd_q         <= bus.Rd_D;
            reg_ren_q    <= bus.reg_ren_D;
            regwrite_q   <= bus.RegWrite_D;
            memread_q    <= bus.MemRead_D;
            memwrite_q   <= bus.MemWrite_D;
            auipc_q      <= bus.auipc_D;
            alu_db_src_q <= bus.ALU_DB_Src_D;
            alu_ctrl_q   <= bus.ALU_ctrl_D;
        end
    end

    assign bus.valid_E      = valid_q;
    assign bus.PC_reg_E     = pc_q;
    assign bus.rdata1_E     = rdata1_q;
    assign bus.rdata2_E     = rdata2_q;
    assign bus.imme_E       = imme_q;
    assign bus.Rs1_E        = rs1_q;
    assign bus.Rs2_E        = rs2_q;
    assign bus.Rd_E         = rd_q;
    assign bus.reg_ren_E    = reg_ren_q;
    assign bus.RegWrite_E   = regwrite_q;
    assign bus.MemRead_E    = memread_q;
    assign bus.MemWrite_E   = memwrite_q;
    assign bus.auipc_E      = auipc_q;
    assign bus.ALU_DB_Src_E = alu_db_src_q;
    assign bus.ALU_ctrl_E   = alu_ctrl_q;
    assign bus.bubble_cnt   = bubble_cnt_q;

endmodule
